// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: MTHI/MTLO, 32-step shift-add multiply,
// restoring divide, MADD/MSUB accumulate, and pipeline stall generation.
module hilo_muldiv_ctrl #(
    parameter int DATA_W = 32,
    parameter int ITERS  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] HIcur,
    input  logic [DATA_W-1:0] LOcur,
    input  logic              ReadReq,
    output logic [DATA_W-1:0] HIdata,
    output logic [DATA_W-1:0] LOdata,
    output logic              HIen,
    output logic              LOen,
    output logic              Busy,
    output logic              Stall,
    output logic              Done,
    output logic [2:0]        state_dbg
);
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_ACC  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
    logic              sign_q, rsign_q;
    logic [CNT_W-1:0]  cnt;

    logic              start_signed, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*DATA_W-1:0] prod, prod_fix, acc_sum;
    logic [DATA_W-1:0] fix_hi, fix_lo;

    // Only the signed ops take magnitudes; the unsigned ones pass operands through.
    always_comb begin
        start_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
        a_neg = start_signed & A[DATA_W-1];
        b_neg = start_signed & B[DATA_W-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo into the remainder held in acc_hi.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = div_shift >= {1'b0, opnd};
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = sign_q ? -prod : prod;
        fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
        fix_lo   = prod_fix[DATA_W-1:0];
        if (op_q[2:1] == 2'b01) begin
            fix_hi = rsign_q ? -acc_hi : acc_hi;
            fix_lo = sign_q  ? -acc_lo : acc_lo;
        end
        acc_sum = op_q[0] ? ({HIcur, LOcur} - prod) : ({HIcur, LOcur} + prod);
    end

    assign Stall     = Busy & (Start | ReadReq);
    assign state_dbg = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            op_q    <= 3'b000;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            cnt     <= '0;
            HIdata  <= '0;
            LOdata  <= '0;
            HIen    <= 1'b0;
            LOen    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            HIen <= 1'b0;
            LOen <= 1'b0;
            Done <= 1'b0;
            case (state)
                S_IDLE: if (Start) begin
                    op_q   <= Op;
                    Busy   <= 1'b1;
                    cnt    <= '0;
                    acc_hi <= '0;
                    case (Op)
                        OP_MTHI: begin
                            HIdata <= A;
                            HIen   <= 1'b1;
                            Done   <= 1'b1;
                            state  <= S_WB;
                        end
                        OP_MTLO: begin
                            LOdata <= A;
                            LOen   <= 1'b1;
                            Done   <= 1'b1;
                            state  <= S_WB;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (B == '0) begin
                                HIdata <= A;
                                LOdata <= '1;
                                HIen   <= 1'b1;
                                LOen   <= 1'b1;
                                Done   <= 1'b1;
                                state  <= S_WB;
                            end else begin
                                acc_lo  <= a_mag;
                                opnd    <= b_mag;
                                sign_q  <= a_neg ^ b_neg;
                                rsign_q <= a_neg;
                                state   <= S_DIV;
                            end
                        end
                        default: begin
                            acc_lo  <= b_mag;
                            opnd    <= a_mag;
                            sign_q  <= a_neg ^ b_neg;
                            rsign_q <= 1'b0;
                            state   <= S_MUL;
                        end
                    endcase
                end
                S_MUL: begin
                    acc_hi <= mul_sum[DATA_W:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= S_FIX;
                end
                S_DIV: begin
                    acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                    acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    acc_hi <= fix_hi;
                    acc_lo <= fix_lo;
                    if (op_q[2:1] == 2'b11) begin
                        state <= S_ACC;
                    end else begin
                        HIdata <= fix_hi;
                        LOdata <= fix_lo;
                        HIen   <= 1'b1;
                        LOen   <= 1'b1;
                        Done   <= 1'b1;
                        state  <= S_WB;
                    end
                end
                S_ACC: begin
                    {HIdata, LOdata} <= acc_sum;
                    HIen  <= 1'b1;
                    LOen  <= 1'b1;
                    Done  <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequencer for the HI/LO register pair in the EX stage of the MIPS pipeline.
- Accepts multiply/divide/move-to ops and runs a 32-iteration shift-add multiply or restoring divide.
- Produces the HI/LO write data and the one-cycle write enables (HIen/LOen) that feed the HI and LO registers.
- Stalls the pipeline when a new HI/LO op or an MFHI/MFLO read arrives while a computation is in flight.

Parameters:
- DATA_W, 32, operand width; HI/LO are each DATA_W bits.
- ITERS, 32, iteration cycles for multiply/divide; must equal DATA_W.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  EX stage presents a HI/LO op this cycle.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- A  in  32  rs operand (dividend / multiplicand / move source).
- B  in  32  rt operand (divisor / multiplier).
- HIcur  in  32  current HI register output (accumulate source).
- LOcur  in  32  current LO register output.
- ReadReq  in  1  MFHI/MFLO in EX this cycle.
- HIdata  out  32  value to write into HI.
- LOdata  out  32  value to write into LO.
- HIen  out  1  HI write enable, one-cycle pulse.
- LOen  out  1  LO write enable, one-cycle pulse.
- Busy  out  1  op in flight, registered.
- Stall  out  1  freeze IF/ID/EX, combinational.
- Done  out  1  one-cycle pulse coincident with the write enables.

Behaviour:
- Reset (async): state IDLE; HIdata, LOdata, HIen, LOen, Busy and Done all 0; internal accumulator, quotient and counter cleared.
- Reset mid-operation aborts the op: no write enable is ever issued for it.
- States: IDLE, MUL, DIV, FIX, ACC, WB.
- Stall = Busy & (Start | ReadReq).
  - Start while Busy is ignored; EX holds and re-presents it.
  - Start is accepted only in IDLE.
- IDLE + Start, per Op:
  - MTHI: latch HIdata=A → WB with HIen only.
  - MTLO: latch LOdata=A → WB with LOen only.
  - MULT/MULTU/MADD/MSUB: latch |A|, |B| (absolute value only for signed ops; MADD/MSUB are signed), record sign = A[31]^B[31]; counter=0 → MUL.
  - DIV/DIVU with B≠0: latch magnitudes; record qsign = A[31]^B[31] and rsign = A[31] (signed only) → DIV.
  - DIV/DIVU with B==0: HIdata=A, LOdata=32'hFFFFFFFF → WB.
- MUL (32 cycles): 64-bit shift-add, one multiplier bit per cycle, LSB first; after counter==31 → FIX.
- DIV (32 cycles): restoring division, one quotient bit per cycle, MSB first; after counter==31 → FIX.
- FIX (1 cycle):
  - Signed ops negate the 64-bit product if sign=1.
  - Signed divide negates the quotient if qsign=1 and the remainder if rsign=1.
  - Divide: HIdata=remainder, LOdata=quotient. Multiply: {HIdata,LOdata}=product.
  - MADD/MSUB → ACC; all other ops → WB.
- ACC (1 cycle): {HIdata,LOdata} = {HIcur,LOcur} ± product, modulo 2^64. HIcur/LOcur are sampled here and must not change during the op; the stall guarantees this.
- WB (1 cycle):
  - HIen and LOen = 1 (only one of them for MTHI/MTLO); Done=1; Busy still 1.
  - An MFHI in the WB cycle stalls and reads the new value next cycle.
  - Next state IDLE.
- Busy = 1 in every non-IDLE state.
- Latency from the Start edge to WB:
  - MTHI/MTLO and divide-by-zero: 1 cycle.
  - MULT/MULTU/DIV/DIVU: 34.
  - MADD/MSUB: 35.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural magnitude result, no trap).
- Enables, Done and the data outputs are registered; HIdata/LOdata hold their last value outside WB.

Test Plan:
- MULT A=7, B=0xFFFFFFFD → after 34 cycles HIen=LOen=Done=1, HIdata=0xFFFFFFFF, LOdata=0xFFFFFFEB; Busy=0 the next cycle.
- MULTU A=B=0xFFFFFFFF → HIdata=0xFFFFFFFE, LOdata=0x00000001; DIV A=0xFFFFFFF9 (−7), B=2 → LOdata=0xFFFFFFFD, HIdata=0xFFFFFFFF.
- DIVU A=0x1234, B=0 → WB one cycle after Start: HIdata=0x1234, LOdata=0xFFFFFFFF, Busy high exactly 1 cycle.
- MADD HIcur=0, LOcur=0xFFFFFFFF, A=B=1 → WB at cycle 35, HIdata=1, LOdata=0. MSUB HIcur=LOcur=0, A=B=1 → HI=LO=0xFFFFFFFF.
- MTHI A=0xDEADBEEF → next cycle HIen=1, LOen=0, HIdata=0xDEADBEEF.
- Stall/abort:
  - ReadReq or Start asserted at cycles 5 and 34 of a MULT → Stall=1 in those cycles; a second Start is not accepted until after WB.
  - Reset pulsed at cycle 10 of a DIV → all outputs 0 immediately; no HIen/LOen pulse thereafter; a new Start is accepted after Reset deasserts.
